// File: rtl/ctrl_regs_pkg.sv
// ctrl_regs_pkg: register map, response codes and CTRL/STATUS field
// positions shared by the AXI4-Lite control register block.
package ctrl_regs_pkg;

    localparam int unsigned CTRL_OFF   = 32'h00;
    localparam int unsigned STATUS_OFF = 32'h04;
    localparam int unsigned COMMIT_OFF = 32'h08;
    localparam int unsigned PARAM_BASE = 32'h10;

    localparam int unsigned CTRL_IDX   = CTRL_OFF >> 2;
    localparam int unsigned STATUS_IDX = STATUS_OFF >> 2;
    localparam int unsigned COMMIT_IDX = COMMIT_OFF >> 2;
    localparam int unsigned PARAM_IDX  = PARAM_BASE >> 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_START     = 0;
    localparam int CTRL_STATE_LSB = 1;
    localparam int CTRL_LAYER_LSB = 3;
    localparam int CTRL_IC_LSB    = 5;
    localparam int CTRL_OC_LSB    = 11;
    localparam int CTRL_IRQ_EN    = 17;

    // Bits of CTRL that are actually stored; start is a pulse only.
    localparam logic [31:0] CTRL_MASK = 32'h0003_FFFE;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_CNT_LSB = 8;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_wr_hold.sv
// axil_wr_hold: one-entry holding register for an AXI-Lite channel.
// Ports: in_valid/in_ready/in_data capture side; out_valid/out_data
// present the held beat; out_pop frees the entry.
module axil_wr_hold #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_pop
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready  = !full_q;
    assign out_valid = full_q;
    assign out_data  = data_q;

    // Pop only happens while full, capture only while empty.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (out_pop) begin
            full_d = 1'b0;
        end
        if (in_valid && !full_q) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/ctrl_regs_axil.sv
// ctrl_regs_axil: AXI4-Lite control/status/parameter registers with
// shadowed params committed atomically. Ports: s_axi_* slave, i_busy/
// i_done status in, CTRL fields, start pulse, params bus, irq out.
module ctrl_regs_axil
    import ctrl_regs_pkg::*;
#(
    parameter int ADDR_W        = 6,
    parameter int N_PARAM_WORDS = 4,
    parameter int PARAM_W       = 80
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ADDR_W-1:0]  s_axi_awaddr,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [31:0]        s_axi_wdata,
    input  logic [3:0]         s_axi_wstrb,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    output logic [1:0]         s_axi_bresp,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    input  logic [ADDR_W-1:0]  s_axi_araddr,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    output logic [31:0]        s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready,
    input  logic               i_busy,
    input  logic               i_done,
    output logic [1:0]         o_state,
    output logic [1:0]         o_current_layer,
    output logic [5:0]         o_current_ic,
    output logic [5:0]         o_current_oc,
    output logic               o_valid,
    output logic [PARAM_W-1:0] o_params,
    output logic               o_params_valid,
    output logic               o_irq
);

    localparam int IW = ADDR_W - 2;
    localparam int SW = 32 * N_PARAM_WORDS;

    logic          aw_full, w_full, wr_fire;
    logic [IW-1:0] aw_h;
    logic [35:0]   w_h;
    logic [31:0]   wd, wr_idx, rd_idx;
    logic [3:0]    ws;

    logic [31:0]        ctrl_q, ctrl_d;
    logic               sticky_q, sticky_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [SW-1:0]      shadow_q, shadow_d;
    logic [PARAM_W-1:0] params_q, params_d;
    logic               pv_q, pv_d, ov_q, ov_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic               rvalid_q, rvalid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        rd_word, status_w;
    logic               rd_hit, wr_hit, ar_fire;
    logic               unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    axil_wr_hold #(.W(IW)) u_aw_hold (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (s_axi_awvalid),
        .in_ready  (s_axi_awready),
        .in_data   (s_axi_awaddr[ADDR_W-1:2]),
        .out_valid (aw_full),
        .out_data  (aw_h),
        .out_pop   (wr_fire)
    );

    axil_wr_hold #(.W(36)) u_w_hold (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (s_axi_wvalid),
        .in_ready  (s_axi_wready),
        .in_data   ({s_axi_wstrb, s_axi_wdata}),
        .out_valid (w_full),
        .out_data  (w_h),
        .out_pop   (wr_fire)
    );

    assign wr_fire = aw_full && w_full && !bvalid_q;
    assign ar_fire = s_axi_arvalid && !rvalid_q;
    assign wr_idx  = 32'(aw_h);
    assign rd_idx  = 32'(s_axi_araddr[ADDR_W-1:2]);
    assign wd      = w_h[31:0];
    assign ws      = w_h[35:32];

    assign status_w = {16'b0, cnt_q, 6'b0, sticky_q, i_busy};

    // Read mux samples current register state, so a read racing a
    // write to the same register returns the pre-write value.
    always_comb begin
        rd_word = '0;
        rd_hit  = 1'b1;
        if (rd_idx == CTRL_IDX) begin
            rd_word = ctrl_q;
        end else if (rd_idx == STATUS_IDX) begin
            rd_word = status_w;
        end else if (rd_idx != COMMIT_IDX) begin
            rd_hit = 1'b0;
            for (int k = 0; k < N_PARAM_WORDS; k++) begin
                if (rd_idx == 32'(PARAM_IDX + k)) begin
                    rd_word = shadow_q[32*k +: 32];
                    rd_hit  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        params_d = params_q;
        pv_d     = 1'b0;
        ov_d     = 1'b0;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        wr_hit   = 1'b0;
        for (int k = 0; k < N_PARAM_WORDS; k++) begin
            if (wr_idx == 32'(PARAM_IDX + k)) begin
                wr_hit = 1'b1;
                if (wr_fire) begin
                    shadow_d[32*k +: 32] =
                        strb_merge(shadow_q[32*k +: 32], wd, ws);
                end
            end
        end
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            if (wr_idx == CTRL_IDX) begin
                ctrl_d = strb_merge(ctrl_q, wd, ws) & CTRL_MASK;
                ov_d   = ws[0] && wd[CTRL_START];
            end else if (wr_idx == STATUS_IDX) begin
                if (ws[0] && wd[STATUS_DONE]) begin
                    sticky_d = 1'b0;
                end
            end else if (wr_idx == COMMIT_IDX) begin
                params_d = shadow_q[PARAM_W-1:0];
                pv_d     = 1'b1;
                cnt_d    = cnt_q + 8'd1;
            end else if (!wr_hit) begin
                bresp_d = RESP_SLVERR;
            end
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        // A done pulse beats a coincident clear.
        if (i_done) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ctrl_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            shadow_q <= '0;
            params_q <= '0;
            pv_q     <= 1'b0;
            ov_q     <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            params_q <= params_d;
            pv_q     <= pv_d;
            ov_q     <= ov_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign s_axi_bvalid    = bvalid_q;
    assign s_axi_bresp     = bresp_q;
    assign s_axi_arready   = !rvalid_q;
    assign s_axi_rvalid    = rvalid_q;
    assign s_axi_rresp     = rresp_q;
    assign s_axi_rdata     = rdata_q;
    assign o_state         = ctrl_q[CTRL_STATE_LSB +: 2];
    assign o_current_layer = ctrl_q[CTRL_LAYER_LSB +: 2];
    assign o_current_ic    = ctrl_q[CTRL_IC_LSB +: 6];
    assign o_current_oc    = ctrl_q[CTRL_OC_LSB +: 6];
    assign o_valid         = ov_q;
    assign o_params        = params_q;
    assign o_params_valid  = pv_q;
    assign o_irq           = sticky_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_ctrl_regs_axil.sv
// tb_ctrl_regs_axil: self-checking bench for ctrl_regs_axil using
// directed scenarios plus randomized traffic against a register model.
module tb_ctrl_regs_axil;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [5:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [5:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic        i_busy = 1'b0;
    logic        i_done = 1'b0;
    logic [1:0]  o_state, o_current_layer;
    logic [5:0]  o_current_ic, o_current_oc;
    logic        o_valid, o_params_valid, o_irq;
    logic [79:0] o_params;

    always #5 clk = ~clk;

    ctrl_regs_axil dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .i_busy(i_busy), .i_done(i_done),
        .o_state(o_state), .o_current_layer(o_current_layer),
        .o_current_ic(o_current_ic), .o_current_oc(o_current_oc),
        .o_valid(o_valid), .o_params(o_params),
        .o_params_valid(o_params_valid), .o_irq(o_irq)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model of the register map
    logic [31:0] m_ctrl;
    logic [31:0] m_param [4];
    logic [79:0] m_pub;
    logic [7:0]  m_cnt;
    logic        m_sticky;
    logic [1:0]  exp_resp;
    logic        exp_ov, exp_pv;

    // Values captured when a response appears
    logic [1:0]  b_resp, r_resp;
    logic        b_ov, b_pv;
    logic [31:0] r_data;

    function automatic logic [31:0] bmerge(input logic [31:0] o,
        input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_ctrl = '0;
        for (int k = 0; k < 4; k++) m_param[k] = '0;
        m_pub = '0;
        m_cnt = '0;
        m_sticky = 1'b0;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [31:0] d,
        input logic [3:0] s);
        logic [127:0] all;
        int i;
        exp_resp = 2'b00;
        exp_ov = 1'b0;
        exp_pv = 1'b0;
        case (a)
            6'h00: begin
                m_ctrl = bmerge(m_ctrl, d, s) & 32'h0003_FFFE;
                exp_ov = s[0] & d[0];
            end
            6'h04: if (s[0] && d[1]) m_sticky = 1'b0;
            6'h08: begin
                all = {m_param[3], m_param[2], m_param[1], m_param[0]};
                m_pub = all[79:0];
                m_cnt = m_cnt + 8'd1;
                exp_pv = 1'b1;
            end
            6'h10, 6'h14, 6'h18, 6'h1C: begin
                i = (int'(a) - 16) / 4;
                m_param[i] = bmerge(m_param[i], d, s);
            end
            default: exp_resp = 2'b10;
        endcase
    endtask

    task automatic model_read(input logic [5:0] a, output logic [31:0] d,
        output logic [1:0] r);
        r = 2'b00;
        d = '0;
        case (a)
            6'h00: d = m_ctrl;
            6'h04: d = {16'b0, m_cnt, 6'b0, m_sticky, i_busy};
            6'h08: d = '0;
            6'h10, 6'h14, 6'h18, 6'h1C: d = m_param[(int'(a) - 16) / 4];
            default: r = 2'b10;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
        input logic [3:0] s, input bit send_aw, input bit send_w);
        bit aw_ok, w_ok;
        int n;
        aw_ok = !send_aw;
        w_ok = !send_w;
        n = 0;
        if (send_aw) begin
            s_axi_awaddr = a;
            s_axi_awvalid = 1'b1;
        end
        if (send_w) begin
            s_axi_wdata = d;
            s_axi_wstrb = s;
            s_axi_wvalid = 1'b1;
        end
        while (!(aw_ok && w_ok) && n < 50) begin
            @(negedge clk);
            if (s_axi_awvalid && s_axi_awready) aw_ok = 1;
            if (s_axi_wvalid && s_axi_wready) w_ok = 1;
            tick();
            if (aw_ok) s_axi_awvalid = 1'b0;
            if (w_ok) s_axi_wvalid = 1'b0;
            n++;
        end
        if (!(aw_ok && w_ok)) begin
            total_cnt++;
            $display("FAIL write_handshake addr=%h got aw=%0d w=%0d need 1 1",
                a, aw_ok, w_ok);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid = 1'b0;
        end
    endtask

    task automatic wait_b();
        bit got;
        int n;
        got = 0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (s_axi_bvalid) begin
                got = 1;
                b_resp = s_axi_bresp;
                b_ov = o_valid;
                b_pv = o_params_valid;
            end
            tick();
            n++;
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL bvalid_timeout got bvalid=0 need 1");
        end
    endtask

    task automatic axi_read(input logic [5:0] a);
        bit ar_ok, got;
        int n;
        ar_ok = 0;
        got = 0;
        n = 0;
        s_axi_araddr = a;
        s_axi_arvalid = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (ar_ok && s_axi_rvalid) begin
                got = 1;
                r_data = s_axi_rdata;
                r_resp = s_axi_rresp;
            end
            if (s_axi_arvalid && s_axi_arready) ar_ok = 1;
            tick();
            if (ar_ok) s_axi_arvalid = 1'b0;
            n++;
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL read_timeout addr=%h got rvalid=0 need 1", a);
            s_axi_arvalid = 1'b0;
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d,
        input logic [3:0] s);
        model_write(a, d, s);
        axi_write(a, d, s, 1, 1);
        wait_b();
        total_cnt++;
        if (b_resp !== exp_resp)
            $display("FAIL wr_bresp a=%h got %b need %b", a, b_resp, exp_resp);
        else pass_cnt++;
    endtask

    task automatic check_read(input logic [5:0] a, input string nm);
        logic [31:0] ed;
        logic [1:0] er;
        axi_read(a);
        model_read(a, ed, er);
        total_cnt++;
        if (r_data !== ed || r_resp !== er)
            $display("FAIL %s a=%h got %h/%b need %h/%b",
                nm, a, r_data, r_resp, ed, er);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
        total_cnt++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
             s_axi_rvalid, s_axi_bresp, s_axi_rresp} !== 9'b111_00_0000)
            $display("FAIL reset_hs got %b need 111000000",
                {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                 s_axi_rvalid, s_axi_bresp, s_axi_rresp});
        else pass_cnt++;
        total_cnt++;
        if ({o_state, o_current_layer, o_current_ic, o_current_oc, o_valid,
             o_params_valid, o_irq, o_params, s_axi_rdata} !== '0)
            $display("FAIL reset_outs got nonzero p=%h rd=%h need 0",
                o_params, s_axi_rdata);
        else pass_cnt++;
        tick();
        check_read(6'h00, "reset_ctrl");
        check_read(6'h04, "reset_status");
        check_read(6'h10, "reset_param0");
    endtask

    task automatic test_w_before_aw();
        model_write(6'h00, 32'h0000_1A2B, 4'hF);
        axi_write(6'h00, 32'h0000_1A2B, 4'hF, 0, 1);
        tick();
        @(negedge clk);
        total_cnt++;
        if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0)
            $display("FAIL w_first_hold got wready=%b bvalid=%b need 0 0",
                s_axi_wready, s_axi_bvalid);
        else pass_cnt++;
        tick();
        axi_write(6'h00, 32'h0, 4'h0, 1, 0);
        wait_b();
        total_cnt++;
        if (b_resp !== 2'b00 || b_ov !== 1'b1)
            $display("FAIL w_first_b got resp=%b ov=%b need 00 1",
                b_resp, b_ov);
        else pass_cnt++;
        total_cnt++;
        if ({o_state, o_current_layer, o_current_ic, o_current_oc} !==
            {2'd1, 2'd1, 6'h11, 6'h03})
            $display("FAIL w_first_fields got %h %h %h %h need 1 1 11 03",
                o_state, o_current_layer, o_current_ic, o_current_oc);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (o_valid !== 1'b0 || s_axi_bvalid !== 1'b0)
            $display("FAIL w_first_once got ov=%b bvalid=%b need 0 0",
                o_valid, s_axi_bvalid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_params();
        do_write(6'h10, 32'h1111_1111, 4'hF);
        do_write(6'h14, 32'h2222_2222, 4'hF);
        do_write(6'h18, 32'h3333_AAAA, 4'hF);
        total_cnt++;
        if (o_params !== 80'h0)
            $display("FAIL params_precommit got %h need 0", o_params);
        else pass_cnt++;
        do_write(6'h08, 32'h0, 4'h0);
        total_cnt++;
        if (b_pv !== 1'b1 || o_params !== 80'hAAAA_2222_2222_1111_1111)
            $display("FAIL params_commit got pv=%b p=%h need 1 %h",
                b_pv, o_params, 80'hAAAA_2222_2222_1111_1111);
        else pass_cnt++;
        total_cnt++;
        if (o_params_valid !== 1'b0)
            $display("FAIL params_pulse got %b need 0", o_params_valid);
        else pass_cnt++;
        axi_read(6'h04);
        total_cnt++;
        if (r_data[15:8] !== 8'd1)
            $display("FAIL commit_cnt got %0d need 1", r_data[15:8]);
        else pass_cnt++;
        do_write(6'h10, 32'h5555_5555, 4'hF);
        total_cnt++;
        if (o_params !== 80'hAAAA_2222_2222_1111_1111)
            $display("FAIL params_hold got %h need %h",
                o_params, 80'hAAAA_2222_2222_1111_1111);
        else pass_cnt++;
    endtask

    task automatic test_strobe();
        do_write(6'h10, 32'hFFFF_FFFF, 4'hF);
        do_write(6'h10, 32'h0000_0000, 4'b0010);
        axi_read(6'h10);
        total_cnt++;
        if (r_data !== 32'hFFFF_00FF)
            $display("FAIL strobe got %h need ffff00ff", r_data);
        else pass_cnt++;
        do_write(6'h00, 32'h0001_2345, 4'b0100);
        check_read(6'h00, "strobe_ctrl");
    endtask

    task automatic test_errors();
        do_write(6'h0C, $urandom, 4'hF);
        total_cnt++;
        if (b_resp !== 2'b10)
            $display("FAIL err_wr got %b need 10", b_resp);
        else pass_cnt++;
        do_write(6'h20, $urandom, 4'hF);
        axi_read(6'h3C);
        total_cnt++;
        if (r_resp !== 2'b10 || r_data !== 32'h0)
            $display("FAIL err_rd got %b/%h need 10/0", r_resp, r_data);
        else pass_cnt++;
        check_read(6'h20, "err_rd_param4");
        check_read(6'h00, "err_ctrl_kept");
        check_read(6'h10, "err_param_kept");
    endtask

    task automatic test_irq();
        do_write(6'h00, 32'h0002_0000, 4'hF);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        m_sticky = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (o_irq !== 1'b1) $display("FAIL irq_set got %b need 1", o_irq);
        else pass_cnt++;
        tick();
        s_axi_awaddr = 6'h04;
        s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h2;
        s_axi_wstrb = 4'hF;
        s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        wait_b();
        model_write(6'h04, 32'h2, 4'hF);
        m_sticky = 1'b1;
        total_cnt++;
        if (o_irq !== 1'b1 || b_resp !== 2'b00)
            $display("FAIL irq_setwins got irq=%b resp=%b need 1 00",
                o_irq, b_resp);
        else pass_cnt++;
        check_read(6'h04, "irq_status");
        do_write(6'h04, 32'h2, 4'h1);
        total_cnt++;
        if (o_irq !== 1'b0) $display("FAIL irq_clear got %b need 0", o_irq);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [5:0] addrs [10] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10,
                                   6'h14, 6'h18, 6'h1C, 6'h20, 6'h3C};
        logic [5:0] a;
        logic [31:0] d;
        logic [3:0] s;
        for (int it = 0; it < 60; it++) begin
            a = addrs[$urandom_range(0, 9)];
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            i_busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s);
                total_cnt++;
                if (b_ov !== exp_ov || b_pv !== exp_pv)
                    $display("FAIL rnd_pulse a=%h got %b%b need %b%b",
                        a, b_ov, b_pv, exp_ov, exp_pv);
                else pass_cnt++;
                total_cnt++;
                if ({o_current_oc, o_current_ic, o_current_layer, o_state,
                     o_params, o_irq} !==
                    {m_ctrl[16:1], m_pub, m_sticky & m_ctrl[17]})
                    $display("FAIL rnd_outs a=%h got %h/%h need %h/%h", a,
                        {o_current_oc, o_current_ic, o_current_layer, o_state},
                        o_params, m_ctrl[16:1], m_pub);
                else pass_cnt++;
            end else begin
                check_read(a, "rnd_read");
            end
        end
        i_busy = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] dv [4];
        int ai, wi, bcnt;
        bit aw_hs, w_hs;
        ai = 0;
        wi = 0;
        bcnt = 0;
        for (int k = 0; k < 4; k++) begin
            dv[k] = $urandom;
            model_write(6'(16 + 4 * k), dv[k], 4'hF);
        end
        s_axi_awaddr = 6'h10;
        s_axi_awvalid = 1'b1;
        s_axi_wdata = dv[0];
        s_axi_wstrb = 4'hF;
        s_axi_wvalid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (s_axi_bvalid) bcnt++;
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs = s_axi_wvalid && s_axi_wready;
            tick();
            if (aw_hs) begin
                ai++;
                if (ai < 4) s_axi_awaddr = 6'(16 + 4 * ai);
                else s_axi_awvalid = 1'b0;
            end
            if (w_hs) begin
                wi++;
                if (wi < 4) s_axi_wdata = dv[wi];
                else s_axi_wvalid = 1'b0;
            end
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        repeat (4) tick();
        total_cnt++;
        if (bcnt != 4 || ai != 4 || wi != 4)
            $display("FAIL b2b_rate got b=%0d aw=%0d w=%0d need 4 4 4",
                bcnt, ai, wi);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) check_read(6'(16 + 4 * k), "b2b_data");
    endtask

    task automatic test_backpressure_reset();
        int n;
        s_axi_bready = 1'b0;
        model_write(6'h00, 32'h0000_0006, 4'hF);
        axi_write(6'h00, 32'h0000_0006, 4'hF, 1, 1);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            tick();
            n++;
        end
        axi_write(6'h14, $urandom, 4'hF, 1, 1);
        repeat (3) tick();
        @(negedge clk);
        total_cnt++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b001)
            $display("FAIL bp_stall got %b need 001",
                {s_axi_awready, s_axi_wready, s_axi_bvalid});
        else pass_cnt++;
        tick();
        check_read(6'h14, "bp_no_commit");
        check_read(6'h00, "bp_first_done");
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        s_axi_bready = 1'b1;
        model_reset();
        @(negedge clk);
        total_cnt++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
             s_axi_rvalid} !== 5'b11100)
            $display("FAIL rst_mid got %b need 11100",
                {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                 s_axi_rvalid});
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if (s_axi_bvalid !== 1'b0 || o_params !== 80'h0 || o_state !== 2'd0)
            $display("FAIL rst_discard got bvalid=%b p=%h st=%h need 0 0 0",
                s_axi_bvalid, o_params, o_state);
        else pass_cnt++;
        check_read(6'h00, "rst_ctrl");
        check_read(6'h14, "rst_param1");
        do_write(6'h14, 32'hCAFE_F00D, 4'hF);
        check_read(6'h14, "rst_rewrite");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running need finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_w_before_aw();
        test_params();
        test_strobe();
        test_errors();
        test_irq();
        test_random();
        test_back_to_back();
        test_backpressure_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
